hazard_control_unit: RTL and testbench

//  Pipeline sequencer paired with the forwarding logic of the 5-stage core (IF/ID/EXE/MEM/WB).

---
 rtl/hazard_pkg.sv | 59 +++++
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_control_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: FSM states, hazard actions in
// priority order, and the per-stage control bundle each action drives.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Listed highest priority first; exactly one action is applied per cycle.
  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_MW    = 3'd1,
    ACT_BR    = 3'd2,
    ACT_DRAIN = 3'd3,
    ACT_LU    = 3'd4,
    ACT_FENCE = 3'd5
  } action_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_exe;
    logic stall_mem;
    logic flush_id;
    logic flush_exe;
    logic bubble_wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;
  localparam logic [4:0] REG_ZERO = '0;

  function automatic ctrl_t action_ctrl(input action_t act);
    ctrl_t c;
    c = CTRL_NONE;
    case (act)
      ACT_MW: begin
        c.stall_if  = 1'b1;
        c.stall_id  = 1'b1;
        c.stall_exe = 1'b1;
        c.stall_mem = 1'b1;
        c.bubble_wb = 1'b1;
      end
      ACT_BR: begin
        c.flush_id  = 1'b1;
        c.flush_exe = 1'b1;
      end
      // Drain, load-use and fence entry all hold the front end and bubble EXE.
      ACT_DRAIN, ACT_LU, ACT_FENCE: begin
        c.stall_if  = 1'b1;
        c.stall_id  = 1'b1;
        c.flush_exe = 1'b1;
      end
      default: c = CTRL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage core: resolves load-use, branch redirect,
// data-memory wait and FENCE drain into per-stage stall/flush controls.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic             valid_id,
  input  logic             is_store_id,
  input  logic             fence_id,
  input  logic [4:0]       rd_exe,
  input  logic             MemRead_exe,
  input  logic             valid_exe,
  input  logic             valid_mem,
  input  logic             valid_wb,
  input  logic             branch_taken_exe,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_exe,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_exe,
  output logic             bubble_wb,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state;
  state_t            state_next;
  action_t           act;
  ctrl_t             ctrl;
  logic [WAIT_W-1:0] wait_cnt;

  logic mw;
  logic br;
  logic lu;
  logic fence;
  logic downstream;
  logic rs1_hit;
  logic rs2_hit;

  assign mw         = valid_mem & dmem_req_mem & ~dmem_ready;
  assign br         = valid_exe & branch_taken_exe;
  assign downstream = valid_exe | valid_mem | valid_wb;

  // Store data (rs2) is covered by WB->MEM forwarding, so only its base address can stall.
  assign rs1_hit = rs1_used_id & (rs1_id == rd_exe);
  assign rs2_hit = rs2_used_id & (rs2_id == rd_exe) & ~is_store_id;
  assign lu      = valid_id & valid_exe & MemRead_exe & (rd_exe != REG_ZERO)
                 & (rs1_hit | rs2_hit);
  assign fence   = valid_id & fence_id & downstream;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    act        = ACT_NONE;
    state_next = state;
    if (mw) begin
      act = ACT_MW;
    end else if (br) begin
      act        = ACT_BR;
      state_next = RUN;
    end else if (state == DRAIN) begin
      if (downstream) begin
        act = ACT_DRAIN;
      end else begin
        state_next = RUN;
      end
    end else if (lu) begin
      act = ACT_LU;
    end else if (fence) begin
      act        = ACT_FENCE;
      state_next = DRAIN;
    end
  end

  // Controls are combinational, so they must be forced quiet while reset is held.
  always_comb begin
    ctrl = CTRL_NONE;
    if (reset_n) begin
      ctrl = action_ctrl(act);
    end
  end

  assign stall_if  = ctrl.stall_if;
  assign stall_id  = ctrl.stall_id;
  assign stall_exe = ctrl.stall_exe;
  assign stall_mem = ctrl.stall_mem;
  assign flush_id  = ctrl.flush_id;
  assign flush_exe = ctrl.flush_exe;
  assign bubble_wb = ctrl.bubble_wb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      if (mw) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
          mem_timeout_err <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ctrl.stall_if),
    .clr     (perf_clr),
    .q       (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (act == ACT_BR),
    .clr     (perf_clr),
    .q       (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit; a second instance with
// a short timeout and narrow counters exercises the timeout and saturation edges.
module tb_hazard_control_unit;

  logic       clk;
  logic       reset_n;
  logic [4:0] rs1_id, rs2_id, rd_exe;
  logic       rs1_used_id, rs2_used_id, valid_id, is_store_id, fence_id;
  logic       MemRead_exe, valid_exe, valid_mem, valid_wb, branch_taken_exe;
  logic       dmem_req_mem, dmem_ready, perf_clr;

  logic        stall_if, stall_id, stall_exe, stall_mem;
  logic        flush_id, flush_exe, bubble_wb, mem_timeout_err;
  logic [31:0] stall_cnt, flush_cnt;

  logic        t_stall_if, t_stall_id, t_stall_exe, t_stall_mem;
  logic        t_flush_id, t_flush_exe, t_bubble_wb, t_err;
  logic [1:0]  t_stall_cnt, t_flush_cnt;

  logic [6:0] ctl;
  assign ctl = {stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe, bubble_wb};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HOLD = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_MW   = 7'b1111001;

  int passed = 0;
  int total  = 0;

  hazard_control_unit dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .valid_id(valid_id), .is_store_id(is_store_id), .fence_id(fence_id),
    .rd_exe(rd_exe), .MemRead_exe(MemRead_exe),
    .valid_exe(valid_exe), .valid_mem(valid_mem), .valid_wb(valid_wb),
    .branch_taken_exe(branch_taken_exe), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr),
    .stall_if(stall_if), .stall_id(stall_id), .stall_exe(stall_exe), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_exe(flush_exe), .bubble_wb(bubble_wb),
    .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_control_unit #(.MEM_TIMEOUT(2), .CNT_W(2)) dut_t (
    .clk(clk), .reset_n(reset_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .valid_id(valid_id), .is_store_id(is_store_id), .fence_id(fence_id),
    .rd_exe(rd_exe), .MemRead_exe(MemRead_exe),
    .valid_exe(valid_exe), .valid_mem(valid_mem), .valid_wb(valid_wb),
    .branch_taken_exe(branch_taken_exe), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr),
    .stall_if(t_stall_if), .stall_id(t_stall_id), .stall_exe(t_stall_exe), .stall_mem(t_stall_mem),
    .flush_id(t_flush_id), .flush_exe(t_flush_exe), .bubble_wb(t_bubble_wb),
    .mem_timeout_err(t_err), .stall_cnt(t_stall_cnt), .flush_cnt(t_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rs1_id = '0; rs2_id = '0; rd_exe = '0;
    rs1_used_id = 0; rs2_used_id = 0; valid_id = 0; is_store_id = 0; fence_id = 0;
    MemRead_exe = 0; valid_exe = 0; valid_mem = 0; valid_wb = 0; branch_taken_exe = 0;
    dmem_req_mem = 0; dmem_ready = 1; perf_clr = 0;
  endtask

  // lw x5 sits in EXE
  task automatic load_in_exe(input logic [4:0] rd);
    valid_exe = 1; MemRead_exe = 1; rd_exe = rd;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    valid_mem = 1; dmem_req_mem = 1; dmem_ready = 0;
    #1;
    if (ctl !== C_NONE) $display("FAIL reset_ctl: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); else passed++;
    total++;
    if (flush_cnt !== 32'd0) $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); else passed++;
    total++;
    if (mem_timeout_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", mem_timeout_err); else passed++;
    total++;
    @(negedge clk);
    idle();
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    // add x6,x5,x1
    load_in_exe(5'd5);
    valid_id = 1; rs1_id = 5'd5; rs2_id = 5'd1; rs1_used_id = 1; rs2_used_id = 1;
    #1;
    if (ctl !== C_HOLD) $display("FAIL lu_stall: got %b expected %b", ctl, C_HOLD); else passed++;
    total++;
    @(negedge clk);
    valid_exe = 0; MemRead_exe = 0;
    #1;
    if (ctl !== C_NONE) $display("FAIL lu_one_bubble: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    if (stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); else passed++;
    total++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_store();
    // sw x5,0(x2): data operand only
    load_in_exe(5'd5);
    valid_id = 1; is_store_id = 1; rs1_id = 5'd2; rs2_id = 5'd5; rs1_used_id = 1; rs2_used_id = 1;
    #1;
    if (ctl !== C_NONE) $display("FAIL store_data: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    @(negedge clk);
    // sw x1,0(x5): base operand
    rs1_id = 5'd5; rs2_id = 5'd1;
    #1;
    if (ctl !== C_HOLD) $display("FAIL store_base: got %b expected %b", ctl, C_HOLD); else passed++;
    total++;
    @(negedge clk);
    if (stall_cnt !== 32'd2) $display("FAIL store_stall_cnt: got %0d expected 2", stall_cnt); else passed++;
    total++;
    // load to x0 never creates a dependency
    idle();
    load_in_exe(5'd0);
    valid_id = 1; rs1_id = 5'd0; rs1_used_id = 1;
    #1;
    if (ctl !== C_NONE) $display("FAIL lu_x0: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_branch();
    load_in_exe(5'd5);
    branch_taken_exe = 1;
    valid_id = 1; rs1_id = 5'd5; rs1_used_id = 1;
    #1;
    if (ctl !== C_BR) $display("FAIL br_over_lu: got %b expected %b", ctl, C_BR); else passed++;
    total++;
    @(negedge clk);
    idle();
    #1;
    if (flush_cnt !== 32'd1) $display("FAIL br_flush_cnt: got %0d expected 1", flush_cnt); else passed++;
    total++;
    if (stall_cnt !== 32'd2) $display("FAIL br_stall_cnt: got %0d expected 2", stall_cnt); else passed++;
    total++;
    @(negedge clk);
  endtask

  task automatic test_mem_wait();
    valid_mem = 1; dmem_req_mem = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ctl !== C_MW) $display("FAIL mw_ctl[%0d]: got %b expected %b", i, ctl, C_MW); else passed++;
      total++;
      if (i == 2) begin
        if (t_err !== 1'b0) $display("FAIL mw_err_early: got %b expected 0", t_err); else passed++;
        total++;
      end
      @(negedge clk);
    end
    dmem_ready = 1;
    #1;
    if (ctl !== C_NONE) $display("FAIL mw_release: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    if (t_err !== 1'b1) $display("FAIL mw_err_set: got %b expected 1", t_err); else passed++;
    total++;
    if (mem_timeout_err !== 1'b0) $display("FAIL mw_err_default: got %b expected 0", mem_timeout_err); else passed++;
    total++;
    if (stall_cnt !== 32'd5) $display("FAIL mw_stall_cnt: got %0d expected 5", stall_cnt); else passed++;
    total++;
    if (t_stall_cnt !== 2'd3) $display("FAIL stall_cnt_saturate: got %0d expected 3", t_stall_cnt); else passed++;
    total++;
    @(negedge clk);
    idle();
    @(negedge clk);
    if (t_err !== 1'b1) $display("FAIL mw_err_sticky: got %b expected 1", t_err); else passed++;
    total++;
  endtask

  task automatic test_perf_clr();
    load_in_exe(5'd7);
    valid_id = 1; rs2_id = 5'd7; rs2_used_id = 1;
    perf_clr = 1;
    #1;
    if (ctl !== C_HOLD) $display("FAIL clr_lu_rs2: got %b expected %b", ctl, C_HOLD); else passed++;
    total++;
    @(negedge clk);
    idle();
    if (stall_cnt !== 32'd0) $display("FAIL clr_stall_cnt: got %0d expected 0", stall_cnt); else passed++;
    total++;
    if (flush_cnt !== 32'd0) $display("FAIL clr_flush_cnt: got %0d expected 0", flush_cnt); else passed++;
    total++;
    @(negedge clk);
  endtask

  task automatic test_fence();
    valid_id = 1; fence_id = 1; valid_exe = 1; valid_mem = 1;
    #1;
    if (ctl !== C_HOLD) $display("FAIL fence_enter: got %b expected %b", ctl, C_HOLD); else passed++;
    total++;
    @(negedge clk);
    valid_exe = 0; valid_mem = 1; valid_wb = 1;
    #1;
    if (ctl !== C_HOLD) $display("FAIL drain_hold: got %b expected %b", ctl, C_HOLD); else passed++;
    total++;
    @(negedge clk);
    dmem_req_mem = 1; dmem_ready = 0;
    #1;
    if (ctl !== C_MW) $display("FAIL drain_mw: got %b expected %b", ctl, C_MW); else passed++;
    total++;
    @(negedge clk);
    dmem_req_mem = 0; dmem_ready = 1; valid_mem = 0;
    #1;
    if (ctl !== C_HOLD) $display("FAIL drain_after_mw: got %b expected %b", ctl, C_HOLD); else passed++;
    total++;
    @(negedge clk);
    valid_wb = 0;
    #1;
    if (ctl !== C_NONE) $display("FAIL drain_empty: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    @(negedge clk);
    fence_id = 0; valid_exe = 1;
    #1;
    if (ctl !== C_NONE) $display("FAIL drain_to_run: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    @(negedge clk);
    idle();
    valid_id = 1; fence_id = 1;
    #1;
    if (ctl !== C_NONE) $display("FAIL fence_empty: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    @(negedge clk);
    fence_id = 0; valid_exe = 1;
    #1;
    if (ctl !== C_NONE) $display("FAIL fence_empty_run: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_branch_in_drain();
    valid_id = 1; fence_id = 1; valid_exe = 1;
    @(negedge clk);
    branch_taken_exe = 1;
    #1;
    if (ctl !== C_BR) $display("FAIL drain_br: got %b expected %b", ctl, C_BR); else passed++;
    total++;
    @(negedge clk);
    branch_taken_exe = 0; fence_id = 0;
    #1;
    if (ctl !== C_NONE) $display("FAIL drain_br_run: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_drain();
    valid_id = 1; fence_id = 1; valid_exe = 1; valid_mem = 1;
    @(negedge clk);
    valid_exe = 0;
    #1;
    if (ctl !== C_HOLD) $display("FAIL rst_drain_pre: got %b expected %b", ctl, C_HOLD); else passed++;
    total++;
    @(negedge clk);
    reset_n = 0;
    #1;
    if (ctl !== C_NONE) $display("FAIL rst_drain_ctl: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    if (t_err !== 1'b0) $display("FAIL rst_drain_err: got %b expected 0", t_err); else passed++;
    total++;
    @(negedge clk);
    reset_n = 1; fence_id = 0;
    #1;
    if (ctl !== C_NONE) $display("FAIL rst_drain_run: got %b expected %b", ctl, C_NONE); else passed++;
    total++;
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_store();
    test_branch();
    test_mem_wait();
    test_perf_clr();
    test_fence();
    test_branch_in_drain();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
